// File: rtl/sgt_serial_pkg.sv
// Shared types and sizing helper for the bit-serial signed comparator.
// No logic; imported by the interface, counter and top.
package sgt_serial_pkg;

    typedef enum logic {
        SIGN,
        MAG
    } state_t;

    typedef enum logic [1:0] {
        UNDEC,
        GT,
        LT
    } dec_t;

    // Counter must index 0..width-1 and never shrink below one bit.
    function automatic int cnt_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sgt_serial_msb_if.sv
// Serial operand link: two operand lanes plus framing in, registered result out.
// EQ lane exists only when SGT_SERIAL_EQ_EN is defined.
interface sgt_serial_msb_if;
    logic I0;
    logic I1;
    logic valid_in;
    logic sync;
    logic O;
    logic valid_out;
`ifdef SGT_SERIAL_EQ_EN
    logic EQ;

    modport master (output I0, I1, valid_in, sync, input O, valid_out, EQ);
    modport slave  (input I0, I1, valid_in, sync, output O, valid_out, EQ);
`else
    modport master (output I0, I1, valid_in, sync, input O, valid_out);
    modport slave  (input I0, I1, valid_in, sync, output O, valid_out);
`endif
endinterface

// File: rtl/sgt_serial_bitcnt.sv
// Framed bit counter: clr restarts the frame (to 1 if inc is also set), inc advances.
// Latency: cnt/last are registered, one cycle after inc/clr. Never stalls.
// Backpressure: none; caller qualifies inc with its own valid.
module sgt_serial_bitcnt
    import sgt_serial_pkg::*;
#(
    parameter int width = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      inc,
    input  logic                      clr,
    output logic [cnt_w(width)-1:0]   cnt,
    output logic                      last
);
    localparam int                CW     = cnt_w(width);
    localparam logic [CW-1:0]     LAST_V = CW'(width - 1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CW'(1) : '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == LAST_V);

endmodule

// File: rtl/sgt_serial_msb.sv
// Bit-serial signed greater-than, MSB first; optional EQ output with SGT_SERIAL_EQ_EN.
// Latency: valid_out/O/EQ register one cycle after the last bit is accepted.
// Backpressure: none; always ready, a word may follow the previous one with no bubble.
module sgt_serial_msb
    import sgt_serial_pkg::*;
#(
    parameter int width = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    sgt_serial_msb_if.slave   bus
);
    state_t                   state, state_nxt;
    dec_t                     dec, dec_nxt;
    dec_t                     msb_dec, mag_dec, fin_dec;
    logic                     is_msb, is_mag, done;
    logic                     cnt_inc, cnt_clr, cnt_last;
    logic [cnt_w(width)-1:0]  cnt;
    logic                     o_q, vld_q;

    sgt_serial_bitcnt #(.width(width)) u_bitcnt (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= SIGN;
            dec   <= UNDEC;
        end else begin
            state <= state_nxt;
            dec   <= dec_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dec_nxt   = dec;
        fin_dec   = dec;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        done      = 1'b0;
        is_msb    = bus.valid_in && (state == SIGN || bus.sync);
        is_mag    = bus.valid_in && !is_msb;

        // Sign bit: a 0 on I0 against a 1 on I1 means I0 is the non-negative one.
        msb_dec = UNDEC;
        if (!bus.I0 && bus.I1)      msb_dec = GT;
        else if (bus.I0 && !bus.I1) msb_dec = LT;

        // First differing magnitude bit decides; later bits cannot override it.
        mag_dec = dec;
        if (dec == UNDEC && bus.I0 != bus.I1) mag_dec = bus.I0 ? GT : LT;

        if (is_msb) begin
            fin_dec   = msb_dec;
            dec_nxt   = msb_dec;
            state_nxt = MAG;
            cnt_clr   = 1'b1;
            cnt_inc   = 1'b1;
            done      = (width == 1);
        end else if (is_mag) begin
            fin_dec   = mag_dec;
            dec_nxt   = mag_dec;
            cnt_inc   = 1'b1;
            done      = cnt_last;
        end else if (bus.sync) begin
            state_nxt = SIGN;
            dec_nxt   = UNDEC;
            cnt_clr   = 1'b1;
        end

        if (done) begin
            state_nxt = SIGN;
            dec_nxt   = UNDEC;
            cnt_clr   = 1'b1;
            cnt_inc   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            o_q   <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= done;
            if (done) o_q <= (fin_dec == GT);
        end
    end

    assign bus.O         = o_q;
    assign bus.valid_out = vld_q;

`ifdef SGT_SERIAL_EQ_EN
    logic eq_q;

    always_ff @(posedge CLK) begin
        if (RESET)     eq_q <= 1'b0;
        else if (done) eq_q <= (fin_dec == UNDEC);
    end

    assign bus.EQ = eq_q;
`endif

    // Between words the counter must be parked at zero.
    always_ff @(posedge CLK) begin
        if (!RESET) assert (state == MAG || cnt == '0);
    end

endmodule

// File: tb/tb_sgt_serial_msb.sv
// Randomized self-checking bench for sgt_serial_msb (width 4 and width 1 instances).
// Expected results come from signed integer comparison of the whole operands.
module tb_sgt_serial_msb;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    sgt_serial_msb_if bus4 ();
    sgt_serial_msb_if bus1 ();

    sgt_serial_msb #(.width(4)) dut4 (.CLK(CLK), .RESET(RESET), .bus(bus4.slave));
    sgt_serial_msb #(.width(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1.slave));

    logic res4_o[$], res4_eq[$], exp4_o[$], exp4_eq[$];
    logic res1_o[$], res1_eq[$], exp1_o[$], exp1_eq[$];

    always @(negedge CLK) begin
        if (bus4.valid_out !== 1'b0) begin
            res4_o.push_back(bus4.O);
`ifdef SGT_SERIAL_EQ_EN
            res4_eq.push_back(bus4.EQ);
`endif
        end
        if (bus1.valid_out !== 1'b0) begin
            res1_o.push_back(bus1.O);
`ifdef SGT_SERIAL_EQ_EN
            res1_eq.push_back(bus1.EQ);
`endif
        end
    end

    // Reference: interpret the raw bits as a w-bit two's-complement integer.
    function automatic int sval(input int v, input int w);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    function automatic void expect4(input int a, input int b);
        exp4_o.push_back(sval(a, 4) > sval(b, 4));
        exp4_eq.push_back(a == b);
    endfunction

    task automatic clear_q();
        res4_o.delete(); res4_eq.delete(); exp4_o.delete(); exp4_eq.delete();
        res1_o.delete(); res1_eq.delete(); exp1_o.delete(); exp1_eq.delete();
    endtask

    task automatic drv4(input logic v, input logic s, input logic a, input logic b);
        @(negedge CLK);
        bus4.valid_in = v; bus4.sync = s; bus4.I0 = a; bus4.I1 = b;
    endtask

    task automatic idle4(input int n);
        repeat (n) drv4(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic s, input int max_gap);
        for (int i = 3; i >= 0; i--) begin
            int g = int'($urandom_range(max_gap, 0));
            repeat (g) drv4(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            drv4(1'b1, s && (i == 3), a[i], b[i]);
        end
    endtask

    task automatic test_reset();
        bus4.valid_in = 1'b1; bus4.sync = 1'b1; bus4.I0 = 1'b0; bus4.I1 = 1'b1;
        bus1.valid_in = 1'b1; bus1.sync = 1'b1; bus1.I0 = 1'b0; bus1.I1 = 1'b1;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (bus4.valid_out !== 1'b0 || bus4.O !== 1'b0) begin
            n_fail++; $display("FAIL reset4: valid_out=%b O=%b required 0 0", bus4.valid_out, bus4.O);
        end
        n_checks++;
        if (bus1.valid_out !== 1'b0 || bus1.O !== 1'b0) begin
            n_fail++; $display("FAIL reset1: valid_out=%b O=%b required 0 0", bus1.valid_out, bus1.O);
        end
`ifdef SGT_SERIAL_EQ_EN
        n_checks++;
        if (bus4.EQ !== 1'b0) begin
            n_fail++; $display("FAIL reset_eq: EQ=%b required 0", bus4.EQ);
        end
`endif
        bus4.valid_in = 1'b0; bus4.sync = 1'b0;
        bus1.valid_in = 1'b0; bus1.sync = 1'b0;
        RESET = 1'b0;
        idle4(2);
        clear_q();
    endtask

    task automatic test_latency();
        logic [3:0] a, b;
        a = 4'b0101; b = 4'b0011;
        for (int i = 3; i >= 0; i--) begin
            drv4(1'b1, i == 3, a[i], b[i]);
            n_checks++;
            if (bus4.valid_out !== 1'b0) begin
                n_fail++; $display("FAIL early_pulse bit%0d: valid_out=%b required 0", i, bus4.valid_out);
            end
        end
        idle4(1);
        n_checks++;
        if (bus4.valid_out !== 1'b1 || bus4.O !== 1'b1) begin
            n_fail++; $display("FAIL latency_5v3: valid_out=%b O=%b required 1 1", bus4.valid_out, bus4.O);
        end
`ifdef SGT_SERIAL_EQ_EN
        n_checks++;
        if (bus4.EQ !== 1'b0) begin
            n_fail++; $display("FAIL latency_eq: EQ=%b required 0", bus4.EQ);
        end
`endif
        idle4(1);
        n_checks++;
        if (bus4.valid_out !== 1'b0 || bus4.O !== 1'b1) begin
            n_fail++; $display("FAIL pulse_width: valid_out=%b O=%b required 0 1", bus4.valid_out, bus4.O);
        end
        idle4(2);
        clear_q();
    endtask

    task automatic test_directed();
        logic [3:0] va[4], vb[4];
        va = '{4'b1101, 4'b0010, 4'b1000, 4'b1111};
        vb = '{4'b0010, 4'b1101, 4'b1000, 4'b1110};
        clear_q();
        for (int k = 0; k < 4; k++) begin
            send4(va[k], vb[k], 1'b1, 0);
            expect4(int'(va[k]), int'(vb[k]));
        end
        idle4(3);
        n_checks++;
        if (res4_o.size() != 4) begin
            n_fail++; $display("FAIL directed_count: got %0d pulses required 4", res4_o.size());
        end
        for (int k = 0; k < 4 && k < res4_o.size(); k++) begin
            n_checks++;
            if (res4_o[k] !== exp4_o[k]) begin
                n_fail++; $display("FAIL directed_O[%0d]: got %b required %b", k, res4_o[k], exp4_o[k]);
            end
`ifdef SGT_SERIAL_EQ_EN
            n_checks++;
            if (res4_eq[k] !== exp4_eq[k]) begin
                n_fail++; $display("FAIL directed_EQ[%0d]: got %b required %b", k, res4_eq[k], exp4_eq[k]);
            end
`endif
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        logic [3:0] a0, b0, a1, b1;
        logic       first[$];
        a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            clear_q();
            send4(a0, b0, 1'b0, pass * 3);
            if (pass == 0) begin
                // The first word's pulse lands while the second word's MSB is sampled.
                send4(a1, b1, 1'b0, 0);
            end else begin
                send4(a1, b1, 1'b0, 3);
            end
            idle4(3);
            expect4(int'(a0), int'(b0));
            expect4(int'(a1), int'(b1));
            n_checks++;
            if (res4_o.size() != 2) begin
                n_fail++; $display("FAIL b2b_count pass%0d: got %0d pulses required 2", pass, res4_o.size());
            end
            for (int k = 0; k < 2 && k < res4_o.size(); k++) begin
                n_checks++;
                if (res4_o[k] !== exp4_o[k]) begin
                    n_fail++; $display("FAIL b2b_O pass%0d[%0d]: got %b required %b", pass, k, res4_o[k], exp4_o[k]);
                end
                if (pass == 0) first.push_back(res4_o[k]);
                else begin
                    n_checks++;
                    if (k < first.size() && res4_o[k] !== first[k]) begin
                        n_fail++; $display("FAIL gap_vs_b2b[%0d]: got %b required %b", k, res4_o[k], first[k]);
                    end
                end
            end
        end
        clear_q();
    endtask

    task automatic test_abandon();
        clear_q();
        drv4(1'b1, 1'b1, 1'b1, 1'b0);
        drv4(1'b1, 1'b0, 1'b1, 1'b0);
        send4(4'b0001, 4'b0000, 1'b1, 0);
        expect4(1, 0);
        // Idle-cycle sync mid-word must drop the partial word too.
        drv4(1'b1, 1'b0, 1'b0, 1'b1);
        drv4(1'b1, 1'b0, 1'b0, 1'b1);
        drv4(1'b0, 1'b1, 1'b0, 1'b0);
        send4(4'b0111, 4'b1000, 1'b0, 0);
        expect4(7, 8);
        idle4(3);
        n_checks++;
        if (res4_o.size() != 2) begin
            n_fail++; $display("FAIL abandon_count: got %0d pulses required 2", res4_o.size());
        end
        for (int k = 0; k < 2 && k < res4_o.size(); k++) begin
            n_checks++;
            if (res4_o[k] !== exp4_o[k]) begin
                n_fail++; $display("FAIL abandon_O[%0d]: got %b required %b", k, res4_o[k], exp4_o[k]);
            end
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        clear_q();
        drv4(1'b1, 1'b1, 1'b0, 1'b1);
        drv4(1'b1, 1'b0, 1'b1, 1'b0);
        RESET = 1'b1;
        drv4(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus4.valid_out !== 1'b0 || bus4.O !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: valid_out=%b O=%b required 0 0", bus4.valid_out, bus4.O);
        end
`ifdef SGT_SERIAL_EQ_EN
        n_checks++;
        if (bus4.EQ !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_eq: EQ=%b required 0", bus4.EQ);
        end
`endif
        RESET = 1'b0;
        send4(4'b0110, 4'b0101, 1'b0, 1);
        idle4(3);
        n_checks++;
        if (res4_o.size() != 1 || res4_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL after_reset_word: pulses=%0d required 1 with O=1", res4_o.size());
        end
        clear_q();
    endtask

    task automatic test_random();
        clear_q();
        for (int w = 0; w < 40; w++) begin
            logic [3:0] a, b;
            logic       s;
            a = 4'($urandom); b = 4'($urandom); s = 1'($urandom);
            if ($urandom_range(4, 0) == 0) begin
                int part = int'($urandom_range(3, 1));
                for (int i = 0; i < part; i++) drv4(1'b1, i == 0, 1'($urandom), 1'($urandom));
                s = 1'b1;
            end
            send4(a, b, s, int'($urandom_range(2, 0)));
            expect4(int'(a), int'(b));
        end
        idle4(3);
        n_checks++;
        if (res4_o.size() != exp4_o.size()) begin
            n_fail++; $display("FAIL random_count: got %0d pulses required %0d", res4_o.size(), exp4_o.size());
        end
        for (int k = 0; k < exp4_o.size() && k < res4_o.size(); k++) begin
            n_checks++;
            if (res4_o[k] !== exp4_o[k]) begin
                n_fail++; $display("FAIL random_O[%0d]: got %b required %b", k, res4_o[k], exp4_o[k]);
            end
`ifdef SGT_SERIAL_EQ_EN
            n_checks++;
            if (res4_eq[k] !== exp4_eq[k]) begin
                n_fail++; $display("FAIL random_EQ[%0d]: got %b required %b", k, res4_eq[k], exp4_eq[k]);
            end
`endif
        end
        clear_q();
    endtask

    task automatic test_width1();
        clear_q();
        for (int c = 0; c < 30; c++) begin
            logic v, a, b;
            v = (c < 4) ? 1'b1 : 1'($urandom);
            a = (c < 4) ? 1'b0 : 1'($urandom);
            b = (c < 4) ? 1'b1 : 1'($urandom);
            @(negedge CLK);
            bus1.valid_in = v; bus1.sync = 1'($urandom); bus1.I0 = a; bus1.I1 = b;
            if (v) begin
                exp1_o.push_back(sval(int'(a), 1) > sval(int'(b), 1));
                exp1_eq.push_back(a == b);
            end
        end
        @(negedge CLK);
        bus1.valid_in = 1'b0; bus1.sync = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (res1_o.size() != exp1_o.size()) begin
            n_fail++; $display("FAIL w1_count: got %0d pulses required %0d", res1_o.size(), exp1_o.size());
        end
        for (int k = 0; k < exp1_o.size() && k < res1_o.size(); k++) begin
            n_checks++;
            if (res1_o[k] !== exp1_o[k]) begin
                n_fail++; $display("FAIL w1_O[%0d]: got %b required %b", k, res1_o[k], exp1_o[k]);
            end
`ifdef SGT_SERIAL_EQ_EN
            n_checks++;
            if (res1_eq[k] !== exp1_eq[k]) begin
                n_fail++; $display("FAIL w1_EQ[%0d]: got %b required %b", k, res1_eq[k], exp1_eq[k]);
            end
`endif
        end
        clear_q();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus4.valid_in = 1'b0; bus4.sync = 1'b0; bus4.I0 = 1'b0; bus4.I1 = 1'b0;
        bus1.valid_in = 1'b0; bus1.sync = 1'b0; bus1.I0 = 1'b0; bus1.I1 = 1'b0;
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_abandon();
        test_reset_mid();
        test_random();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
